// File: rtl/demux_1a4.sv
// -----------------------------------------------------------------------------
// demux_1a4 -- registered 1-to-3 demultiplexer with valid/ready handshaking.
//
// Routes one WIDTH-bit word to one of three destinations using the same code
// map as the datapath's 4-to-1 input mux: Ctrl 00/01/10 select destinations
// 1/2/3, and 11 discards the word. An accepted word is held on its Salida
// until that destination takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Upstream is in_valid/in_ready; downstream is valid<d>/ready<d>. The
// producer must hold Ctrl/Entrada stable while in_valid is high and in_ready
// is low. Each Salida/valid pair holds until its ready is seen high.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   Ctrl[1:0], Entrada       destination code and data, qualified by in_valid
//   in_valid / in_ready      upstream handshake (in_ready is combinational
//                            from ready1..3 and the state only)
//   Salida1..3, valid1..3    registered data and "undelivered word" flags
//   ready1..3                destination accepts its word this cycle
//   dbg_state[1:0]           current FSM state (0 idle, 1..3 busy dest 1..3)
//   drop_cnt[15:0]           saturating count of discarded words; present only
//                            when DEMUX_DROP_CNT_EN is defined
// -----------------------------------------------------------------------------
module demux_1a4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Ctrl,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Salida1,
    output logic [WIDTH-1:0] Salida2,
    output logic [WIDTH-1:0] Salida3,
    output logic             valid1,
    output logic             valid2,
    output logic             valid3,
    input  logic             ready1,
    input  logic             ready2,
    input  logic             ready3,
    output logic [1:0]       dbg_state
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    // BUSY is split per destination so the held destination is the state
    // itself; each valid is then a plain decode and at most one can be high.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY1 = 2'd1,
        S_BUSY2 = 2'd2,
        S_BUSY3 = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic delivered;
    logic accept;
    logic load1, load2, load3;
    logic discard;

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        delivered = 1'b0;
        load1     = 1'b0;
        load2     = 1'b0;
        load3     = 1'b0;
        discard   = 1'b0;

        // Only the ready of the held destination matters.
        case (state)
            S_BUSY1: delivered = ready1;
            S_BUSY2: delivered = ready2;
            S_BUSY3: delivered = ready3;
            default: delivered = 1'b0;
        endcase

        in_ready = (state == S_IDLE) || delivered;
        accept   = in_valid && in_ready;

        if (delivered) begin
            state_nxt = S_IDLE;
        end

        // A new word accepted on the delivery edge overrides the return to
        // idle, so back-to-back words flow with no bubble.
        if (accept) begin
            case (Ctrl)
                2'b00: begin
                    state_nxt = S_BUSY1;
                    load1     = 1'b1;
                end
                2'b01: begin
                    state_nxt = S_BUSY2;
                    load2     = 1'b1;
                end
                2'b10: begin
                    state_nxt = S_BUSY3;
                    load3     = 1'b1;
                end
                default: begin
                    state_nxt = S_IDLE;
                    discard   = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Unselected buses keep their last contents; only the selected one loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Salida1 <= '0;
            Salida2 <= '0;
            Salida3 <= '0;
        end else begin
            if (load1) Salida1 <= Entrada;
            if (load2) Salida2 <= Entrada;
            if (load3) Salida3 <= Entrada;
        end
    end

    assign valid1    = (state == S_BUSY1);
    assign valid2    = (state == S_BUSY2);
    assign valid3    = (state == S_BUSY3);
    assign dbg_state = state;

`ifdef DEMUX_DROP_CNT_EN
    // Saturating: once at all-ones it sticks until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (discard && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_demux_1a4.sv
// -----------------------------------------------------------------------------
// tb_demux_1a4 -- directed self-checking bench for demux_1a4.
// Inputs change on the falling edge; registered outputs are sampled 1 ns
// after the rising edge, combinational in_ready 1 ns after inputs change.
// -----------------------------------------------------------------------------
module tb_demux_1a4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  Ctrl;
    logic [31:0] Entrada;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Salida1, Salida2, Salida3;
    logic        valid1, valid2, valid3;
    logic        ready1, ready2, ready3;
    logic [1:0]  dbg_state;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected contents of each Salida bus (index 1..3).
    logic [31:0] exp_s [1:3];

    demux_1a4 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ctrl      (Ctrl),
        .Entrada   (Entrada),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Salida1   (Salida1),
        .Salida2   (Salida2),
        .Salida3   (Salida3),
        .valid1    (valid1),
        .valid2    (valid2),
        .valid3    (valid3),
        .ready1    (ready1),
        .ready2    (ready2),
        .ready3    (ready3),
        .dbg_state (dbg_state)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] sal(input int d);
        case (d)
            1:       return Salida1;
            2:       return Salida2;
            default: return Salida3;
        endcase
    endfunction

    function automatic logic vld(input int d);
        case (d)
            1:       return valid1;
            2:       return valid2;
            default: return valid3;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        Ctrl     = 2'b00;
        Entrada  = 32'hFFFF_FFFF;
        ready1   = 1'b0;
        ready2   = 1'b0;
        ready3   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 1; d <= 3; d++) begin
            n_checks++;
            if (sal(d) !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_salida%0d: got %h expected 00000000", d, sal(d));
            end
            n_checks++;
            if (vld(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid%0d: got %b expected 0", d, vld(d));
            end
            exp_s[d] = 32'h0;
        end
`ifdef DEMUX_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt);
        end
`endif
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_routing();
        logic [31:0] word;
        ready1 = 1'b1;
        ready2 = 1'b1;
        ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word = (i == 0) ? 32'hAAAA_0001 : (i == 1) ? 32'h0000_BEEF : 32'h1234_5678;
            @(negedge clk);
            in_valid = 1'b1;
            Ctrl     = 2'(i);
            Entrada  = word;
            @(posedge clk);
            #1;
            exp_s[i+1] = word;
            for (int d = 1; d <= 3; d++) begin
                n_checks++;
                if (vld(d) !== (d == i + 1)) begin
                    n_fail++;
                    $display("FAIL route%0d_valid%0d: got %b expected %b", i, d, vld(d), (d == i + 1));
                end
                n_checks++;
                if (sal(d) !== exp_s[d]) begin
                    n_fail++;
                    $display("FAIL route%0d_salida%0d: got %h expected %h", i, d, sal(d), exp_s[d]);
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            n_checks++;
            if (vld(i + 1) !== 1'b0) begin
                n_fail++;
                $display("FAIL route%0d_one_cycle: valid%0d got %b expected 0", i, i + 1, vld(i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        ready1 = 1'b1;
        ready2 = 1'b0;
        ready3 = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        Ctrl     = 2'b01;
        Entrada  = 32'hCAFE_0000;
        @(posedge clk);
        #1;
        exp_s[2] = 32'hCAFE_0000;
        n_checks++;
        if (valid2 !== 1'b1 || Salida2 !== 32'hCAFE_0000) begin
            n_fail++;
            $display("FAIL bp_load: valid2=%b Salida2=%h expected 1 cafe0000", valid2, Salida2);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            Ctrl     = 2'b00;
            Entrada  = 32'hDEAD_0000 + 32'(k);
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready%0d: got %b expected 0", k, in_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (valid2 !== 1'b1 || Salida2 !== 32'hCAFE_0000) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid2=%b Salida2=%h expected 1 cafe0000", k, valid2, Salida2);
            end
            n_checks++;
            if (valid1 !== 1'b0 || Salida1 !== exp_s[1]) begin
                n_fail++;
                $display("FAIL bp_no_capture%0d: valid1=%b Salida1=%h expected 0 %h", k, valid1, Salida1, exp_s[1]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        ready2   = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_delivered: valid2 got %b expected 0", valid2);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        ready1 = 1'b1;
        ready2 = 1'b0;
        ready3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = (k % 2 == 0) ? 1 : 3;
            @(negedge clk);
            in_valid = 1'b1;
            Ctrl     = (d == 1) ? 2'b00 : 2'b10;
            Entrada  = 32'h1000_0000 + 32'(k);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready%0d: got %b expected 1", k, in_ready);
            end
            @(posedge clk);
            #1;
            exp_s[d] = 32'h1000_0000 + 32'(k);
            n_checks++;
            if (vld(d) !== 1'b1 || sal(d) !== exp_s[d] || vld(4 - d) !== 1'b0 || valid2 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_word%0d: v1=%b v2=%b v3=%b Salida%0d=%h expected valid%0d only, %h",
                         k, valid1, valid2, valid3, d, sal(d), d, exp_s[d]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({valid1, valid2, valid3} !== 3'b000 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_drain: valids=%b state=%0d expected 000 0", {valid1, valid2, valid3}, dbg_state);
        end
    endtask

    task automatic test_discard();
        ready1 = 1'b1;
        ready2 = 1'b1;
        ready3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            Ctrl     = 2'b11;
            Entrada  = 32'h5A5A_0000 + 32'(k);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_in_ready%0d: got %b expected 1", k, in_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({valid1, valid2, valid3} !== 3'b000 || Salida1 !== exp_s[1]
                || Salida2 !== exp_s[2] || Salida3 !== exp_s[3]) begin
                n_fail++;
                $display("FAIL drop_word%0d: valids=%b s1=%h s2=%h s3=%h expected 000 %h %h %h",
                         k, {valid1, valid2, valid3}, Salida1, Salida2, Salida3, exp_s[1], exp_s[2], exp_s[3]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
        #1;
        n_checks++;
        if (drop_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL drop_cnt_3: got %h expected 0003", drop_cnt);
        end
        force dut.drop_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.drop_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            Ctrl     = 2'b11;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (drop_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL drop_cnt_sat: got %h expected ffff", drop_cnt);
        end
`endif
    endtask

    // Delivery of a held word and acceptance of a code-11 word on one edge.
    task automatic test_deliver_and_drop();
        ready1 = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        Ctrl     = 2'b00;
        Entrada  = 32'h7777_0001;
        @(posedge clk);
        #1;
        exp_s[1] = 32'h7777_0001;
        n_checks++;
        if (valid1 !== 1'b1 || Salida1 !== exp_s[1]) begin
            n_fail++;
            $display("FAIL dd_load: valid1=%b Salida1=%h expected 1 %h", valid1, Salida1, exp_s[1]);
        end
        @(negedge clk);
        ready1 = 1'b1;
        Ctrl   = 2'b11;
        @(posedge clk);
        #1;
        n_checks++;
        if ({valid1, valid2, valid3} !== 3'b000 || dbg_state !== 2'd0 || Salida1 !== exp_s[1]) begin
            n_fail++;
            $display("FAIL dd_idle: valids=%b state=%0d Salida1=%h expected 000 0 %h",
                     {valid1, valid2, valid3}, dbg_state, Salida1, exp_s[1]);
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
        #1;
        n_checks++;
        if (drop_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL dd_drop_cnt_stuck: got %h expected ffff", drop_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        ready3 = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        Ctrl     = 2'b10;
        Entrada  = 32'h3333_3333;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (valid3 !== 1'b1 || Salida3 !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL rm_held: valid3=%b Salida3=%h expected 1 33333333", valid3, Salida3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid3 !== 1'b0 || Salida3 !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_async_clear: valid3=%b Salida3=%h expected 0 00000000", valid3, Salida3);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        Ctrl     = 2'b00;
        Entrada  = 32'h0BAD_F00D;
        ready1   = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (valid1 !== 1'b1 || Salida1 !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL rm_first_accept: valid1=%b Salida1=%h expected 1 0badf00d", valid1, Salida1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ready1   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_discard();
        test_deliver_and_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
